// File: rtl/avst_mc_packet_gen.sv
// avst_mc_packet_gen: multi-channel Avalon-ST packet generator (readyLatency 0).
// Each accepted command emits one packet on its channel. Every beat carries the
// channel's 8-bit packet sequence number and the beat index, so a sink-side
// checker can spot drops, reordering and channel mix-ups.
// Optional build macro AVST_GEN_STATS_EN adds stat_clr / stat_beats / stat_stalls.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SEND  | streaming beats of the current packet, src_valid held high
module avst_mc_packet_gen #(
    parameter int DATA_W       = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int CHANNEL_W    = 2,
    parameter int LEN_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHANNEL_W-1:0] cmd_channel,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 src_valid,
    input  logic                 src_ready,
    output logic [DATA_W-1:0]    src_data,
    output logic [CHANNEL_W-1:0] src_channel,
    output logic                 src_startofpacket,
    output logic                 src_endofpacket,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
`ifdef AVST_GEN_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [31:0]          stat_beats,
    output logic [31:0]          stat_stalls
`endif
);

    typedef enum logic {IDLE, SEND} state_t;

    // One extra bit so a channel count of exactly 2**CHANNEL_W still compares correctly.
    localparam logic [CHANNEL_W:0] NUM_CH = (CHANNEL_W+1)'(NUM_CHANNELS);

    state_t         state;
    logic [LEN_W:0] beat_idx;     // one bit wider than len so a full-length packet cannot wrap
    logic [LEN_W:0] len_q;
    logic [7:0]     seq [NUM_CHANNELS];

    logic           cmd_fire;
    logic           ch_ok;
    logic           xfer;
    logic [LEN_W:0] next_idx;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign ch_ok    = {1'b0, cmd_channel} < NUM_CH;
    assign xfer     = src_valid && src_ready;
    assign next_idx = beat_idx + 1'b1;

    // Packet FSM with all outputs registered; src_valid depends on state only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cmd_ready         <= 1'b1;
            src_valid         <= 1'b0;
            src_data          <= '0;
            src_channel       <= '0;
            src_startofpacket <= 1'b0;
            src_endofpacket   <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            cmd_err           <= 1'b0;
            beat_idx          <= '0;
            len_q             <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                seq[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (ch_ok) begin
                            state             <= SEND;
                            cmd_ready         <= 1'b0;
                            busy              <= 1'b1;
                            src_valid         <= 1'b1;
                            src_channel       <= cmd_channel;
                            len_q             <= {1'b0, cmd_len};
                            beat_idx          <= '0;
                            src_data          <= {seq[cmd_channel], {(DATA_W-8){1'b0}}};
                            src_startofpacket <= 1'b1;
                            src_endofpacket   <= (cmd_len == '0);
                        end else begin
                            // Out-of-range channel: drop the command, touch nothing else.
                            cmd_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (src_endofpacket) begin
                            seq[src_channel]  <= seq[src_channel] + 8'd1;
                            state             <= IDLE;
                            cmd_ready         <= 1'b1;
                            busy              <= 1'b0;
                            src_valid         <= 1'b0;
                            done              <= 1'b1;
                            src_startofpacket <= 1'b0;
                            src_endofpacket   <= 1'b0;
                        end else begin
                            beat_idx          <= next_idx;
                            src_data          <= {seq[src_channel], (DATA_W-8)'(next_idx)};
                            src_startofpacket <= 1'b0;
                            src_endofpacket   <= (next_idx == len_q);
                        end
                    end
                end
            endcase
        end
    end

`ifdef AVST_GEN_STATS_EN
    // Saturating beat and stall counters; stat_clr wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else if (stat_clr) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (xfer && (stat_beats != '1)) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if (src_valid && !src_ready && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/avst_mc_packet_gen.md
Name: avst_mc_packet_gen

Overview:
Parametrised, multi-channel Avalon-ST packet generator with readyLatency 0. It builds packets on command and drives them into the Qsys Avalon-ST sink under test, in place of hand-scripted source-BFM sequences in the user test program. Each channel keeps its own packet sequence counter, so a sink-side checker can detect drops, reordering and channel mix-ups. It sits beside the testbench system and is instantiated from the test top.

Parameters:
DATA_W, 32, source data width in bits; must be at least 16.
NUM_CHANNELS, 4, number of logical channels; must be at least 1.
CHANNEL_W, 2, channel field width; must satisfy 2**CHANNEL_W >= NUM_CHANNELS.
LEN_W, 8, width of the length field; packets carry 1..2**LEN_W beats.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_channel  in  CHANNEL_W  target channel
cmd_len  in  LEN_W  beats minus one
src_valid  out  1  Avalon-ST valid
src_ready  in  1  Avalon-ST ready
src_data  out  DATA_W  payload
src_channel  out  CHANNEL_W  channel of current packet
src_startofpacket  out  1  first beat
src_endofpacket  out  1  last beat
busy  out  1  packet in progress
done  out  1  one-cycle pulse after the last beat transfers
cmd_err  out  1  one-cycle pulse when a command is dropped

Behaviour:
- Reset, asynchronous on reset_n low:
  - cmd_ready = 1; src_valid, sop, eop, busy, done, cmd_err = 0.
  - src_data and src_channel = 0.
  - All per-channel sequence counters = 0; FSM goes to IDLE.
- FSM states: IDLE, SEND.
- IDLE:
  - cmd_ready = 1.
  - On command accept with cmd_channel < NUM_CHANNELS: latch channel and len, clear beat index, go to SEND. src_valid rises on the next cycle, so command-to-first-valid latency is 1 clock.
  - On command accept with cmd_channel >= NUM_CHANNELS: pulse cmd_err for 1 cycle the next cycle, stay in IDLE, leave every counter unchanged.
- SEND:
  - cmd_ready = 0, busy = 1, src_valid = 1 continuously.
  - A beat transfers when src_valid && src_ready.
  - While src_ready is low, src_data, src_channel, sop and eop hold stable.
  - Beat payload: src_data = {seq[ch][7:0], beat_idx[DATA_W-9:0]} with beat_idx zero-extended.
  - sop = (beat_idx == 0); eop = (beat_idx == len).
  - On a transfer with eop:
    - seq[ch] increments; it is 8-bit and wraps 255 -> 0.
    - Next cycle: src_valid = 0, busy = 0, done = 1 for 1 cycle, state returns to IDLE.
  - A transfer without eop increments beat_idx.
- A single-beat packet (cmd_len = 0) asserts sop and eop on the same beat.
- A maximum-length packet (cmd_len = all ones) carries 2**LEN_W beats; beat_idx is LEN_W+1 bits wide internally so it cannot wrap.
- Back-to-back packets: there is a minimum 1-cycle gap between packets. The done cycle is IDLE with cmd_ready = 1, so the earliest next first beat is 2 cycles after the previous eop transfer.
- Reset asserted mid-packet: the packet is truncated with no eop, all outputs return to reset values immediately, and all sequence counters clear.
- src_valid never deasserts inside a packet; it depends only on state, never combinationally on src_ready.

Optional Feature:
Macro: AVST_GEN_STATS_EN.
- Defined:
  - Adds outputs stat_beats (32 bits, counts every transferred beat) and stat_stalls (32 bits, counts cycles with src_valid && !src_ready).
  - Both counters reset to 0, saturate at all ones, and are cleared by input stat_clr (1 bit, synchronous, takes priority over increment).
- Undefined: those ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then cmd ch=1 len=3 with src_ready held at 1 -> 4 beats on consecutive cycles, data 0x00000000..0x00000003, sop on beat 0, eop on beat 3, done pulses the cycle after beat 3.
- Second cmd ch=1 len=0 -> one beat with data 0x01000000 and sop=eop=1; seq[1] = 2 afterwards.
- cmd ch=2 len=2 with src_ready low on cycles 2-4 of the packet -> src_data held stable while stalled, exactly 3 transfers, no beat duplicated or skipped; with the macro defined, stat_stalls = 3 and stat_beats = 3.
- NUM_CHANNELS=3, cmd ch=3 -> cmd_err pulses once, src_valid stays 0, all seq counters unchanged.
- 256 packets on ch=0, len=0 -> the 257th packet's data upper byte wraps to 0x00.
- Assert reset_n low during beat 2 of a len=7 packet -> src_valid = 0 immediately; after release a new cmd ch=0 produces seq byte 0x00 and sop on its first beat.
